// File: rtl/fp_mul_pkg.sv
// Shared constants, operand classes and format helpers for the pipelined FP multiplier.
package fp_mul_pkg;

  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;

  typedef enum logic [2:0] {
    CLS_ZERO,
    CLS_NORM,
    CLS_INF,
    CLS_QNAN,
    CLS_SNAN
  } fp_cls_e;

  // Bit positions inside the 5-bit {NV,DZ,OF,UF,NX} flag vector
  localparam int FLG_NV = 4;
  localparam int FLG_DZ = 3;
  localparam int FLG_OF = 2;
  localparam int FLG_UF = 1;
  localparam int FLG_NX = 0;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic logic [63:0] fp_canon_nan(input int exp_w, input int man_w);
    return (((64'd1 << exp_w) - 64'd1) << man_w) | (64'd1 << (man_w - 1));
  endfunction

  function automatic logic [63:0] fp_max_finite(input int exp_w, input int man_w);
    return ((64'd1 << (exp_w + man_w)) - 64'd1) & ~(64'd1 << man_w);
  endfunction

endpackage

// File: rtl/fp_mul_round.sv
// Combinational normalise/round/pack of a raw mantissa product; zero latency, no flow control.
// Flag outputs exist only when FP_MUL_FLAGS_EN is defined.
module fp_mul_round
  import fp_mul_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   sign,
  input  logic [EXP_W+1:0]       exp,
  input  logic [2*MAN_W+1:0]     prod,
  input  logic [2:0]             rm,
  output logic [EXP_W+MAN_W:0]   result
`ifdef FP_MUL_FLAGS_EN
  , output logic [4:0]           flags
`endif
);

  localparam int FP_W = 1 + EXP_W + MAN_W;
  localparam int EW   = EXP_W + 2;
  localparam int PW   = 2 * MAN_W + 2;
  localparam logic [63:0]   MAXF64  = fp_max_finite(EXP_W, MAN_W);
  localparam logic [EW-1:0] EXP_MAX = {2'b00, {EXP_W{1'b1}}};

  logic             hi, g, r, s, inc, to_inf, tiny, ovf;
  logic [MAN_W-1:0] frac_t;
  logic [MAN_W:0]   mant;
  logic [EW-1:0]    e_r;

  always_comb begin
    // Product lies in [1,4): when bit PW-1 is set the window shifts right by one
    hi     = prod[PW-1];
    frac_t = hi ? prod[PW-2:MAN_W+1] : prod[PW-3:MAN_W];
    g      = hi ? prod[MAN_W]        : prod[MAN_W-1];
    r      = hi ? prod[MAN_W-1]      : prod[MAN_W-2];
    s      = hi ? |prod[MAN_W-2:0]   : |prod[MAN_W-3:0];

    case (rm)
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = sign & (g | r | s);
      RM_RUP:  inc = ~sign & (g | r | s);
      RM_RMM:  inc = g;
      default: inc = g & (r | s | frac_t[0]);
    endcase

    case (rm)
      RM_RTZ:  to_inf = 1'b0;
      RM_RDN:  to_inf = sign;
      RM_RUP:  to_inf = ~sign;
      default: to_inf = 1'b1;
    endcase

    mant = {1'b0, frac_t} + {{MAN_W{1'b0}}, inc};
    e_r  = exp + {{(EW-1){1'b0}}, hi} + {{(EW-1){1'b0}}, mant[MAN_W]};
    tiny = e_r[EW-1] | (e_r == '0);
    ovf  = ~e_r[EW-1] & (e_r >= EXP_MAX);

    if (tiny)
      result = {sign, {(FP_W-1){1'b0}}};
    else if (ovf)
      result = to_inf ? {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}} : {sign, MAXF64[FP_W-2:0]};
    else
      result = {sign, e_r[EXP_W-1:0], mant[MAN_W-1:0]};
  end

`ifdef FP_MUL_FLAGS_EN
  always_comb begin
    flags         = '0;
    flags[FLG_UF] = tiny;
    flags[FLG_OF] = ovf & ~tiny;
    flags[FLG_NX] = tiny | ovf | g | r | s;
  end
`endif

endmodule

// File: rtl/fp_mul_pipe.sv
// 3-stage IEEE multiplier (unpack, multiply, round); 3 cycles accept->out_valid, 1 op/cycle.
// Whole pipe freezes while out_valid && !out_ready; fflags port only with FP_MUL_FLAGS_EN.
module fp_mul_pipe
  import fp_mul_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] op_a,
  input  logic [EXP_W+MAN_W:0] op_b,
  input  logic [2:0]           rm,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] result,
  output logic [TAG_W-1:0]     out_tag
`ifdef FP_MUL_FLAGS_EN
  , output logic [4:0]         fflags
`endif
);

  localparam int FP_W = 1 + EXP_W + MAN_W;
  localparam int EW   = EXP_W + 2;
  localparam int PW   = 2 * MAN_W + 2;
  localparam logic [63:0]   NAN64  = fp_canon_nan(EXP_W, MAN_W);
  localparam logic [EW-1:0] BIAS_E = EW'(fp_bias(EXP_W));

  function automatic fp_cls_e classify(input logic [FP_W-2:0] x);
    if (x[FP_W-2:MAN_W] == '0) return CLS_ZERO;
    if (x[FP_W-2:MAN_W] == '1) begin
      if (x[MAN_W-1:0] == '0) return CLS_INF;
      if (x[MAN_W-1])         return CLS_QNAN;
      return CLS_SNAN;
    end
    return CLS_NORM;
  endfunction

  logic adv;
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  logic             s1_vld, s1_sign;
  logic [TAG_W-1:0] s1_tag;
  logic [2:0]       s1_rm;
  fp_cls_e          s1_cls_a, s1_cls_b;
  logic [EXP_W-1:0] s1_exp_a, s1_exp_b;
  logic [MAN_W:0]   s1_man_a, s1_man_b;

  logic             s2_vld, s2_sign, s2_spec;
  logic [TAG_W-1:0] s2_tag;
  logic [2:0]       s2_rm;
  logic [EW-1:0]    s2_exp;
  logic [PW-1:0]    s2_prod;
  logic [FP_W-1:0]  s2_spec_res;

  logic nan_any, inf_any, zero_any, inf_zero, spec;
  logic [FP_W-1:0] spec_res, rnd_res;

  assign nan_any  = (s1_cls_a == CLS_QNAN) | (s1_cls_a == CLS_SNAN) |
                    (s1_cls_b == CLS_QNAN) | (s1_cls_b == CLS_SNAN);
  assign inf_any  = (s1_cls_a == CLS_INF) | (s1_cls_b == CLS_INF);
  assign zero_any = (s1_cls_a == CLS_ZERO) | (s1_cls_b == CLS_ZERO);
  assign inf_zero = inf_any & zero_any;

  // Special operands bypass the rounder entirely
  always_comb begin
    spec     = 1'b1;
    spec_res = '0;
    if (nan_any | inf_zero) spec_res = NAN64[FP_W-1:0];
    else if (inf_any)       spec_res = {s1_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else if (zero_any)      spec_res = {s1_sign, {(FP_W-1){1'b0}}};
    else                    spec     = 1'b0;
  end

`ifdef FP_MUL_FLAGS_EN
  logic       nv, s2_nv;
  logic [4:0] rnd_flags;
  assign nv = (s1_cls_a == CLS_SNAN) | (s1_cls_b == CLS_SNAN) | (~nan_any & inf_zero);
`endif

  fp_mul_round #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_round (
    .sign   (s2_sign),
    .exp    (s2_exp),
    .prod   (s2_prod),
    .rm     (s2_rm),
    .result (rnd_res)
`ifdef FP_MUL_FLAGS_EN
    , .flags(rnd_flags)
`endif
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_vld    <= 1'b0;
      s2_vld    <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      out_tag   <= '0;
`ifdef FP_MUL_FLAGS_EN
      fflags    <= '0;
`endif
    end else if (adv) begin
      s1_vld    <= in_valid;
      s2_vld    <= s1_vld;
      out_valid <= s2_vld;
      if (s2_vld) begin
        result  <= s2_spec ? s2_spec_res : rnd_res;
        out_tag <= s2_tag;
`ifdef FP_MUL_FLAGS_EN
        fflags  <= s2_spec ? {s2_nv, 4'b0000} : rnd_flags;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      s1_tag      <= in_tag;
      s1_rm       <= rm;
      s1_sign     <= op_a[FP_W-1] ^ op_b[FP_W-1];
      s1_cls_a    <= classify(op_a[FP_W-2:0]);
      s1_cls_b    <= classify(op_b[FP_W-2:0]);
      s1_exp_a    <= op_a[FP_W-2:MAN_W];
      s1_exp_b    <= op_b[FP_W-2:MAN_W];
      s1_man_a    <= {1'b1, op_a[MAN_W-1:0]};
      s1_man_b    <= {1'b1, op_b[MAN_W-1:0]};
      s2_tag      <= s1_tag;
      s2_rm       <= s1_rm;
      s2_sign     <= s1_sign;
      s2_exp      <= {2'b00, s1_exp_a} + {2'b00, s1_exp_b} - BIAS_E;
      s2_prod     <= {{(MAN_W+1){1'b0}}, s1_man_a} * {{(MAN_W+1){1'b0}}, s1_man_b};
      s2_spec     <= spec;
      s2_spec_res <= spec_res;
`ifdef FP_MUL_FLAGS_EN
      s2_nv       <= nv;
`endif
    end
  end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Randomised and directed bench for fp_mul_pipe against an exact-integer rounding model.
module tb_fp_mul_pipe;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] op_a, op_b, result;
  logic [2:0]  rm;
  logic [4:0]  in_tag, out_tag;
`ifdef FP_MUL_FLAGS_EN
  logic [4:0]  fflags;
`endif

  always #5 clk = ~clk;

  fp_mul_pipe dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .rm        (rm),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .out_tag   (out_tag)
`ifdef FP_MUL_FLAGS_EN
    , .fflags  (fflags)
`endif
  );

  typedef struct {
    logic [31:0] res;
    logic [4:0]  tag;
    logic [4:0]  flg;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   acc_cnt = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Exact product rounded by comparing the discarded remainder against one half-ulp
  function automatic logic [36:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] m);
    int ea, eb, e, sh;
    logic s, nan_a, nan_b, inf_a, inf_b, z_a, z_b, sn, inc, up;
    longint unsigned p, q, rem, half;
    ea    = int'(a[30:23]);
    eb    = int'(b[30:23]);
    s     = a[31] ^ b[31];
    nan_a = (ea == 255) && (a[22:0] != 0);
    nan_b = (eb == 255) && (b[22:0] != 0);
    sn    = (nan_a && !a[22]) || (nan_b && !b[22]);
    inf_a = (ea == 255) && (a[22:0] == 0);
    inf_b = (eb == 255) && (b[22:0] == 0);
    z_a   = (ea == 0);
    z_b   = (eb == 0);
    if (nan_a || nan_b) return {sn, 4'b0000, 32'h7FC00000};
    if ((inf_a && z_b) || (z_a && inf_b)) return {5'b10000, 32'h7FC00000};
    if (inf_a || inf_b) return {5'b00000, s, 8'hFF, 23'h0};
    if (z_a || z_b) return {5'b00000, s, 31'h0};
    p    = 64'({1'b1, a[22:0]}) * 64'({1'b1, b[22:0]});
    sh   = p[47] ? 24 : 23;
    e    = ea + eb - 127 + (p[47] ? 1 : 0);
    q    = p >> sh;
    rem  = p - (q << sh);
    half = 64'd1 << (sh - 1);
    case (m)
      3'd1:    inc = 1'b0;
      3'd2:    inc = s && (rem != 0);
      3'd3:    inc = !s && (rem != 0);
      3'd4:    inc = (rem >= half);
      default: inc = (rem > half) || ((rem == half) && q[0]);
    endcase
    q = q + 64'(inc);
    if (q == (64'd1 << 24)) begin
      q = 64'd1 << 23;
      e = e + 1;
    end
    if (e < 1) return {5'b00011, s, 31'h0};
    if (e >= 255) begin
      case (m)
        3'd1:    up = 1'b0;
        3'd2:    up = s;
        3'd3:    up = !s;
        default: up = 1'b1;
      endcase
      return up ? {5'b00101, s, 8'hFF, 23'h0} : {5'b00101, s, 8'hFE, 23'h7FFFFF};
    end
    return {4'b0000, (rem != 0), s, e[7:0], q[22:0]};
  endfunction

  function automatic logic [31:0] rnd_op();
    logic [7:0]  e;
    logic [22:0] f;
    int k;
    k = $urandom_range(0, 9);
    f = 23'($urandom);
    case (k)
      0:       e = 8'h00;
      1:       e = 8'hFF;
      2:       e = 8'($urandom);
      3:       e = 8'($urandom_range(1, 20));
      4:       e = 8'($urandom_range(235, 254));
      default: e = 8'($urandom_range(100, 154));
    endcase
    if ($urandom_range(0, 5) == 0) f = '0;
    else if ($urandom_range(0, 7) == 0) f = '1;
    return {1'($urandom), e, f};
  endfunction

  // Entered and left just after a rising edge
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [2:0] m,
                       input logic [4:0] t, input logic [31:0] xr, input logic [4:0] xf,
                       input bit rnd_rdy);
    exp_t e;
    bit   ok;
    op_a = a; op_b = b; rm = m; in_tag = t; in_valid = 1'b1;
    e.res = xr; e.tag = t; e.flg = xf;
    ok = 1'b0;
    for (int w = 0; w < 200; w++) begin
      if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (ok) begin
      sb.push_back(e);
      acc_cnt++;
    end else begin
      check("accept_timeout", 64'(in_ready), 64'(1));
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic issue_rnd(input logic [4:0] t, input bit rnd_rdy);
    logic [31:0] a, b;
    logic [2:0]  m;
    logic [36:0] x;
    a = rnd_op();
    b = rnd_op();
    m = 3'($urandom_range(0, 7));
    x = ref_mul(a, b, m);
    issue(a, b, m, t, x[31:0], x[36:32], rnd_rdy);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int w = 0; w < 100; w++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    check("drain", 64'(sb.size()), 64'(0));
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("spurious_out", 64'(sb.size()), 64'(1));
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", 64'(result), 64'(e.res));
        check("tag", 64'(out_tag), 64'(e.tag));
`ifdef FP_MUL_FLAGS_EN
        check("fflags", 64'(fflags), 64'(e.flg));
`endif
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  localparam int ND = 12;
  logic [31:0] d_a  [ND] = '{32'h3F800001, 32'h3F800001, 32'h3F800001, 32'h7F000000,
                             32'h7F000000, 32'hFF000000, 32'h7F800000, 32'h7F800001,
                             32'h7FC00000, 32'h00800000, 32'h80000001, 32'h00000000};
  logic [31:0] d_b  [ND] = '{32'h3F800001, 32'h3F800001, 32'h3F800001, 32'h7F000000,
                             32'h7F000000, 32'h7F000000, 32'h00000000, 32'h3F800000,
                             32'h3F800000, 32'h3F000000, 32'h40000000, 32'h7F800000};
  logic [2:0]  d_rm [ND] = '{3'd0, 3'd3, 3'd1, 3'd0, 3'd1, 3'd2, 3'd0, 3'd0,
                             3'd0, 3'd0, 3'd0, 3'd0};
  logic [31:0] d_r  [ND] = '{32'h3F800002, 32'h3F800003, 32'h3F800002, 32'h7F800000,
                             32'h7F7FFFFF, 32'hFF800000, 32'h7FC00000, 32'h7FC00000,
                             32'h7FC00000, 32'h00000000, 32'h80000000, 32'h7FC00000};
  logic [4:0]  d_f  [ND] = '{5'h01, 5'h01, 5'h01, 5'h05, 5'h05, 5'h05, 5'h10, 5'h10,
                             5'h00, 5'h03, 5'h00, 5'h10};

  initial begin
    exp_t e1;
    int   lat, acc0;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    op_a = '0; op_b = '0; rm = '0; in_tag = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_result", 64'(result), 64'(0));
    check("rst_out_tag", 64'(out_tag), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));
`ifdef FP_MUL_FLAGS_EN
    check("rst_fflags", 64'(fflags), 64'(0));
`endif
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Latency: 2.0 x 3.0
    op_a = 32'h40000000; op_b = 32'h40400000; rm = 3'd0; in_tag = 5'd19; in_valid = 1'b1;
    e1.res = 32'h40C00000; e1.tag = 5'd19; e1.flg = 5'h00;
    sb.push_back(e1);
    @(negedge clk);
    check("t1_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    check("t1_latency", 64'(lat), 64'(3));
    @(posedge clk); #1;

    for (int i = 0; i < ND; i++)
      issue(d_a[i], d_b[i], d_rm[i], 5'(i), d_r[i], d_f[i], 1'b0);
    drain();

    for (int i = 0; i < 400; i++) begin
      issue_rnd(5'(i), 1'b1);
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk); #1;
      end
    end
    drain();

    // Six ops against a consumer stalled for five cycles
    acc0 = acc_cnt;
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) issue_rnd(5'(20 + i), 1'b0);
      end
      begin
        repeat (3) @(negedge clk);
        check("stall_rdy_hi", 64'(in_ready), 64'(1));
        @(negedge clk);
        check("stall_rdy_lo", 64'(in_ready), 64'(0));
        check("stall_accepted", 64'(acc_cnt - acc0), 64'(3));
        @(negedge clk);
        check("stall_hold", 64'(out_valid), 64'(1));
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with two ops in flight
    issue_rnd(5'd7, 1'b0);
    issue_rnd(5'd8, 1'b0);
    reset = 1'b1;
    sb.delete();
    @(negedge clk);
    check("rst_flush", 64'(out_valid), 64'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("rst_quiet", 64'(out_valid), 64'(0));
    end
    @(posedge clk); #1;

    for (int i = 0; i < 20; i++) issue_rnd(5'(i + 3), 1'b1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
